// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: decode-stage immediate extender.
// Extends a narrow immediate field to a full-width operand using one of four
// modes. The unit registers its result with valid/ready on both sides. A
// second (skid) entry lets the producer complete one more transfer after the
// consumer stalls, so no item is lost or duplicated.
//
// Parameter legality: 2 <= IN_W <= OUT_W, IN_W + SHIFT <= OUT_W.
module imm_extend_pipe #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16,
  parameter int SHIFT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg
);

  // Number of bits added above the field (zero when IN_W == OUT_W).
  localparam int PAD = OUT_W - IN_W;

  // Bits above the immediate field. This mask is all-zero when IN_W == OUT_W,
  // because the shifted 1 falls off the top.
  localparam logic [OUT_W-1:0] HI_MASK =
    ~((OUT_W'(1) << IN_W) - OUT_W'(1));

  typedef enum logic [1:0] {
    MODE_ZEXT  = 2'd0,
    MODE_SEXT  = 2'd1,
    MODE_SHIFT = 2'd2,
    MODE_UPPER = 2'd3
  } mode_e;

  // One buffered result: the extended operand plus its valid bit.
  typedef struct packed {
    logic             vld;
    logic [OUT_W-1:0] data;
  } ent_t;

  ent_t             r_m;      // main entry, drives out_*
  ent_t             r_k;      // skid entry, only valid while r_m is valid
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_ext;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Extension of the immediate currently offered on the input.
  always_comb begin
    w_zext = OUT_W'(in_data);
    w_sext = w_zext | (in_data[IN_W-1] ? HI_MASK : '0);
    unique case (mode_e'(in_mode))
      MODE_ZEXT:  w_ext = w_zext;
      MODE_SEXT:  w_ext = w_sext;
      MODE_SHIFT: w_ext = w_sext << SHIFT;
      MODE_UPPER: w_ext = w_zext << PAD;
      default:    w_ext = w_zext;
    endcase
  end

  // Handshakes. in_ready depends only on state and reset, not on out_ready,
  // so there is no combinational path from out_ready to in_ready.
  always_comb begin
    in_ready   = !r_k.vld && !reset;
    out_valid  = r_m.vld;
    out_data   = r_m.data;
    out_neg    = r_m.data[OUT_W-1];
    w_in_xfer  = in_valid && in_ready;
    w_out_xfer = r_m.vld && out_ready;
  end

  // Two-entry skid buffer. The skid entry refills the main entry first. The
  // main entry takes a new input only when it is empty or being drained, so
  // out_data holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m <= '0;
      r_k <= '0;
    end else if (w_out_xfer && r_k.vld) begin
      r_m.data <= r_k.data;
      r_k.vld  <= 1'b0;
    end else if (w_out_xfer || !r_m.vld) begin
      if (w_in_xfer) begin
        r_m.vld  <= 1'b1;
        r_m.data <= w_ext;
      end else begin
        r_m.vld  <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_k.vld  <= 1'b1;
      r_k.data <= w_ext;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: table vectors plus a scoreboard for imm_extend_pipe.
// The driver pushes each item's expected operand when the item is accepted.
// A negedge monitor pops and compares every output transfer. It also checks
// handshake consistency against a tracked occupancy count, and checks output
// stability while the consumer stalls.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_neg;

  // Second instance: IN_W == OUT_W, no shift.
  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  in_data8 = '0;
  logic [1:0]  in_mode8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [7:0]  out_data8;
  logic        out_neg8;

  imm_extend_pipe #(.IN_W(5), .OUT_W(16), .SHIFT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_neg(out_neg));

  imm_extend_pipe #(.IN_W(8), .OUT_W(8), .SHIFT(0)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_mode(in_mode8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .out_neg(out_neg8));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  m;
    logic [4:0]  d;
    logic [15:0] e;
  } vec_t;

  typedef struct {
    logic [15:0] e;
    int          acc;
  } sb_t;

  sb_t         exp_q[$];
  int          nchk = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          occ = 0;
  int          rdy_mode = 0;   // 0: out_ready low, 1: high, 2: random
  bit          chk_lat = 1'b0;
  bit          have_hold = 1'b0;
  logic [15:0] hold_d = '0;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference extension for IN_W=5, OUT_W=16, SHIFT=1, computed arithmetically.
  function automatic logic [15:0] model(input logic [1:0] m, input logic [4:0] d);
    int v;
    v = int'(d);
    if (d[4]) v = v - 32;
    case (m)
      2'd0:    return {11'b0, d};
      2'd1:    return 16'(v);
      2'd2:    return 16'(v * 2);
      default: return {d, 11'b0};
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: out_ready changes only just after a rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: checks sampled at the falling edge describe the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      occ = 0;
      exp_q.delete();
      have_hold = 1'b0;
    end else begin
      chk(in_ready == (occ < 2), "in_ready_vs_occupancy", 32'(in_ready), 32'(occ < 2));
      chk(out_valid == (occ > 0), "out_valid_vs_occupancy", 32'(out_valid), 32'(occ > 0));
      if (have_hold && out_valid)
        chk(out_data == hold_d, "stall_stability", 32'(out_data), 32'(hold_d));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_output", 32'(out_data), 32'hDEAD);
        end else begin
          sb_t s;
          s = exp_q.pop_front();
          chk(out_data == s.e, "out_data", 32'(out_data), 32'(s.e));
          chk(out_neg == s.e[15], "out_neg", 32'(out_neg), 32'(s.e[15]));
          if (chk_lat)
            chk(cyc - s.acc == 1, "latency", 32'(cyc - s.acc), 32'd1);
        end
      end
      have_hold = out_valid && !out_ready;
      hold_d    = out_data;
      occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end
  end

  // Offer one item until accepted. The expected value is pushed on acceptance.
  // Returns just after the rising edge that takes the item.
  task automatic send(input logic [1:0] m, input logic [4:0] d, input logic [15:0] e);
    int n;
    sb_t s;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        s.e = e;
        s.acc = cyc;
        exp_q.push_back(s);
        break;
      end
      n++;
      if (n > 200) begin
        chk(1'b0, "send_timeout", 32'(n), 32'd200);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(n < 500, "drain_timeout", 32'(n), 32'd500);
  endtask

  initial begin
    vec_t tbl[6];
    sb_t  s;
    tbl[0] = '{2'd1, 5'b01010, 16'h000A};
    tbl[1] = '{2'd1, 5'b11010, 16'hFFFA};
    tbl[2] = '{2'd0, 5'b11010, 16'h001A};
    tbl[3] = '{2'd2, 5'b11010, 16'hFFF4};
    tbl[4] = '{2'd3, 5'b11010, 16'hD000};
    tbl[5] = '{2'd2, 5'b01111, 16'h001E};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(in_ready == 1'b0, "in_ready_in_reset", 32'(in_ready), 32'd0);
    chk(out_valid == 1'b0, "out_valid_in_reset", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk(in_ready == 1'b1, "in_ready_after_reset", 32'(in_ready), 32'd1);
    chk(out_data == 16'h0, "out_data_after_reset", 32'(out_data), 32'd0);
    chk(out_neg == 1'b0, "out_neg_after_reset", 32'(out_neg), 32'd0);

    // Table vectors, back-to-back with out_ready high and one-cycle latency.
    rdy_mode = 1;
    @(posedge clk); #1;
    chk_lat = 1'b1;
    for (int i = 0; i < 6; i++) send(tbl[i].m, tbl[i].d, tbl[i].e);
    drain();
    chk_lat = 1'b0;

    // Backpressure: A and B fill both entries, and C waits at the source.
    @(negedge clk);
    rdy_mode = 0;
    @(posedge clk); #1;
    send(2'd0, 5'b00001, 16'h0001);
    send(2'd0, 5'b00010, 16'h0002);
    in_valid = 1'b1; in_mode = 2'd3; in_data = 5'b11111;   // ignored while full
    @(negedge clk);
    chk(in_ready == 1'b0, "bp_full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_mode = 2'd0; in_data = 5'b00011;
    @(negedge clk);
    chk(in_ready == 1'b0, "bp_hold_in_ready", 32'(in_ready), 32'd0);
    chk(out_data == 16'h0001, "bp_stall_data", 32'(out_data), 32'h1);
    rdy_mode = 1;
    @(negedge clk);
    chk(out_valid && out_data == 16'h0001, "bp_out_A", 32'(out_data), 32'h1);
    chk(in_ready == 1'b0, "bp_in_ready_A", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk(out_valid && out_data == 16'h0002, "bp_out_B", 32'(out_data), 32'h2);
    chk(in_ready == 1'b1, "bp_in_ready_reassert", 32'(in_ready), 32'd1);
    s.e = 16'h0003; s.acc = cyc;
    exp_q.push_back(s);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk(out_valid && out_data == 16'h0003, "bp_out_C", 32'(out_data), 32'h3);
    drain();

    // Random streaming under random backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] m;
      logic [4:0] d;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      m = 2'($urandom_range(0, 3));
      d = 5'($urandom_range(0, 31));
      send(m, d, model(m, d));
    end
    @(negedge clk);
    rdy_mode = 1;
    drain();

    // Reset with two items buffered and an item offered during reset.
    @(negedge clk);
    rdy_mode = 0;
    @(posedge clk); #1;
    send(2'd1, 5'b10101, model(2'd1, 5'b10101));
    send(2'd0, 5'b00111, model(2'd0, 5'b00111));
    in_valid = 1'b1; in_mode = 2'd3; in_data = 5'b11100;
    reset = 1'b1;
    @(negedge clk);
    chk(in_ready == 1'b0, "rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b0, "rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk(out_data == 16'h0, "rst_mid_out_data", 32'(out_data), 32'd0);
    chk(out_neg == 1'b0, "rst_mid_out_neg", 32'(out_neg), 32'd0);
    chk(in_ready == 1'b1, "rst_mid_in_ready_after", 32'(in_ready), 32'd1);
    rdy_mode = 1;
    @(posedge clk); #1;
    send(2'd1, 5'b10000, 16'hFFF0);
    drain();

    // IN_W == OUT_W, SHIFT == 0: every mode passes 0x80 through.
    for (int m = 0; m < 4; m++) begin
      in_valid8 = 1'b1; in_mode8 = 2'(m); in_data8 = 8'h80;
      @(negedge clk);
      chk(in_ready8 == 1'b1, "w8_in_ready", 32'(in_ready8), 32'd1);
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      @(negedge clk);
      chk(out_valid8 && out_data8 == 8'h80, "w8_out_data", 32'(out_data8), 32'h80);
      chk(out_neg8 == 1'b1, "w8_out_neg", 32'(out_neg8), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
